// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder step per clock, LSB first
// Ports: clk/reset (sync, active-high); start with a, b, cin captured in IDLE;
// busy high during RUN; done one-cycle pulse; sum/cout registered and held until the next result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [CW-1:0] cnt;
  logic c, s_bit, c_nxt;
  always_comb begin
    s_bit = a_sh[0] ^ b_sh[0] ^ c;
    c_nxt = (a_sh[0] & b_sh[0]) | (b_sh[0] & c) | (c & a_sh[0]);
    state_nxt = state == IDLE ? (start ? RUN : IDLE) :
                state == RUN  ? (cnt == LAST ? DONE : RUN) : IDLE;
    busy = state == RUN;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a_sh <= a;
        b_sh <= b;
        c    <= cin;
        cnt  <= '0;
      end
      if (state == RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        c    <= c_nxt;
        acc  <= {s_bit, acc[WIDTH-1:1]};
        cnt  <= cnt + 1'b1;
        // the final sum bit is folded in directly so the result lands on the edge entering DONE
        if (cnt == LAST) begin
          sum  <= {s_bit, acc[WIDTH-1:1]};
          cout <= c_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=16
module tb_serial_adder;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, cin = 1'b0, busy, done, cout;
  logic [7:0] a = '0, b = '0, sum;
  logic start16 = 1'b0, cin16 = 1'b0, busy16, done16, cout16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic [8:0] q8[$];
  logic [16:0] q16[$];
  int n_cmp = 0, n_err = 0, nd;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (busy && done) begin
      n_cmp++;
      n_err++;
      $display("FAIL busy_done_excl8: busy and done both high");
    end
    if (done) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done8: sum=%0h cout=%0b with nothing pending", sum, cout);
      end else chk("result8", {cout, sum}, q8.pop_front());
    end
  end
  always @(negedge clk) begin
    if (busy16 && done16) begin
      n_cmp++;
      n_err++;
      $display("FAIL busy_done_excl16: busy and done both high");
    end
    if (done16) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done16: sum=%0h cout=%0b with nothing pending", sum16, cout16);
      end else chk("result16", {cout16, sum16}, q16.pop_front());
    end
  end
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int lat = 0, nb = 0;
    a = x; b = y; cin = ci; start = 1'b1;
    q8.push_back(9'(x) + 9'(y) + 9'(ci));
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
      end
      if (busy) nb++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("latency8", lat, 9);
    chk("busy_cycles8", nb, 8);
    @(negedge clk);
  endtask
  task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int lat = 0;
    a16 = x; b16 = y; cin16 = ci; start16 = 1'b1;
    q16.push_back(17'(x) + 17'(y) + 17'(ci));
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
      if (done16) begin
        lat = k;
        break;
      end
    end
    chk("latency16", lat, 17);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    reset = 1'b0;
    @(negedge clk);
    run8(8'h5A, 8'h33, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_sum", sum, 8'h8D);
    chk("hold_cout", cout, 0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    q8.push_back(9'h046);
    nd = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == 3 || k == 9);
      if (k == 3 || k == 9) begin
        a = 8'hAA; b = 8'h55; cin = 1'b1;
      end
      if (done) nd++;
    end
    start = 1'b0;
    chk("ignored_one_done", nd, 1);
    chk("ignored_sum", sum, 8'h46);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run8(8'h01, 8'h02, 1'b1);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    repeat (4) q8.push_back(9'h100);
    nd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk("hold_phase", k % 10, 9);
      end
    end
    start = 1'b0;
    chk("hold_count", nd, 4);
    @(negedge clk);
    for (int i = 0; i < 1000; i++) run8(8'($urandom), 8'($urandom), 1'($urandom));
    run16(16'hFFFF, 16'h0001, 1'b0);
    run16(16'hFFFF, 16'hFFFF, 1'b1);
    run16(16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 300; i++) run16(16'($urandom), 16'($urandom), 1'($urandom));
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
